seven_segment_disp: RTL and testbench

//  Registered 5-digit signed BCD to seven-segment decoder for the board display path.

---
 rtl/seven_segment_disp.sv | 107 ++++++++++
 tb/tb_seven_segment_disp.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_disp.sv
// seven_segment_disp: registered 5-digit signed BCD to seven-segment decoder.
// Drives five digit bytes plus a sign byte; invalid nibbles (A-F) show 'E'.
// Optional feature macro: LZB_EN -- when defined, leading zero digits are blanked.
// Segment byte layout is {dp,g,f,e,d,c,b,a}; dp is never lit.
module seven_segment_disp #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] bcd_input,
    output logic [7:0]  out0,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic [7:0]  out4,
    output logic [7:0]  dout
);

    localparam logic [7:0] CODE_BLANK = 8'h00;
    localparam logic [7:0] CODE_MINUS = 8'h40;
    localparam logic [7:0] CODE_ERR   = 8'h79;

    // Output value of a fully dark digit, taking pin polarity into account.
    localparam logic [7:0] PIN_BLANK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Active-high segment pattern for one nibble; anything above 9 is shown as 'E'.
    function automatic logic [7:0] decodeDigit(input logic [3:0] nibble);
        logic [7:0] code;
        case (nibble)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = CODE_ERR;
        endcase
        return code;
    endfunction

    // Convert an active-high pattern to the level driven on the pins.
    function automatic logic [7:0] toPins(input logic [7:0] code);
        return SEG_ACTIVE_LOW ? ~code : code;
    endfunction

    logic [3:0] digit      [5];
    logic [4:0] nonZero;
    logic [4:0] significant;
    logic [7:0] digitSeg_d [5];
    logic [7:0] digitSeg_q [5];
    logic [7:0] signSeg_d;
    logic [7:0] signSeg_q;

    // Split the input into digits and work out which digits are significant,
    // scanning from the most significant digit downwards.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            digit[i]   = bcd_input[4*i +: 4];
            nonZero[i] = (bcd_input[4*i +: 4] != 4'd0);
        end
        significant[4] = nonZero[4];
        significant[3] = significant[4] | nonZero[3];
        significant[2] = significant[3] | nonZero[2];
        significant[1] = significant[2] | nonZero[1];
        significant[0] = 1'b1;
    end

    // Build the next segment bytes; non-significant digits go dark only when blanking is built in.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
`ifdef LZB_EN
            digitSeg_d[i] = significant[i] ? toPins(decodeDigit(digit[i])) : toPins(CODE_BLANK);
`else
            digitSeg_d[i] = toPins(decodeDigit(digit[i]));
`endif
        end
        // Negative zero is shown unsigned: minus only when some digit is nonzero or invalid.
        signSeg_d = (bcd_input[20] && (|nonZero)) ? toPins(CODE_MINUS) : toPins(CODE_BLANK);
    end

    // Register all six display bytes; reset darkens the whole display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                digitSeg_q[i] <= PIN_BLANK;
            end
            signSeg_q <= PIN_BLANK;
        end else begin
            for (int i = 0; i < 5; i++) begin
                digitSeg_q[i] <= digitSeg_d[i];
            end
            signSeg_q <= signSeg_d;
        end
    end

    assign out0 = digitSeg_q[0];
    assign out1 = digitSeg_q[1];
    assign out2 = digitSeg_q[2];
    assign out3 = digitSeg_q[3];
    assign out4 = digitSeg_q[4];
    assign dout = signSeg_q;

endmodule

// File: tb/tb_seven_segment_disp.sv
// tb_seven_segment_disp: directed and randomized checks of seven_segment_disp
// (SEG_ACTIVE_LOW=1) against a digit-by-digit reference model.
// The model follows LZB_EN the same way the design build does.
module tb_seven_segment_disp;

    logic        clk;
    logic        rst;
    logic [20:0] bcd_input;
    logic [7:0]  out0, out1, out2, out3, out4, dout;

    int checkCount = 0;
    int passCount  = 0;

    seven_segment_disp #(.SEG_ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_input (bcd_input),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .dout      (dout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: pin byte for digit position idx (0..4) or the sign (idx 5).
    function automatic logic [7:0] modelByte(input logic [20:0] value, input int idx);
        byte unsigned numerals [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        int  digits [5];
        bit  seenLeading;
        bit  lit [5];
        logic [7:0] activeHigh;
        int  magnitudeNonZero;
        magnitudeNonZero = 0;
        for (int i = 0; i < 5; i++) begin
            digits[i] = (int'(value) >> (4 * i)) % 16;
            if (digits[i] != 0) magnitudeNonZero = 1;
        end
        seenLeading = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (digits[i] != 0 || i == 0) seenLeading = 1'b1;
`ifdef LZB_EN
            lit[i] = seenLeading;
`else
            lit[i] = 1'b1;
`endif
        end
        if (idx == 5) begin
            activeHigh = (value[20] && magnitudeNonZero != 0) ? 8'h40 : 8'h00;
        end else if (!lit[idx]) begin
            activeHigh = 8'h00;
        end else if (digits[idx] > 9) begin
            activeHigh = 8'h79;
        end else begin
            activeHigh = numerals[digits[idx]];
        end
        return ~activeHigh;
    endfunction

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
        end
    endtask

    // Compare all six outputs against the model for one input value.
    task automatic checkAll(input string tag, input logic [20:0] value);
        checkOutput({tag, ".out0"}, out0, modelByte(value, 0));
        checkOutput({tag, ".out1"}, out1, modelByte(value, 1));
        checkOutput({tag, ".out2"}, out2, modelByte(value, 2));
        checkOutput({tag, ".out3"}, out3, modelByte(value, 3));
        checkOutput({tag, ".out4"}, out4, modelByte(value, 4));
        checkOutput({tag, ".dout"}, dout, modelByte(value, 5));
    endtask

    // Drive one value, let it be captured on the next edge, then check shortly after.
    task automatic applyStimulus(input string tag, input logic [20:0] value);
        bcd_input = value;
        @(posedge clk);
        #1;
        checkAll(tag, value);
    endtask

    // Check every output is dark.
    task automatic checkBlank(input string tag);
        checkOutput({tag, ".out0"}, out0, 8'hFF);
        checkOutput({tag, ".out1"}, out1, 8'hFF);
        checkOutput({tag, ".out2"}, out2, 8'hFF);
        checkOutput({tag, ".out3"}, out3, 8'hFF);
        checkOutput({tag, ".out4"}, out4, 8'hFF);
        checkOutput({tag, ".dout"}, dout, 8'hFF);
    endtask

    logic [20:0] directed [8] = '{21'h000000, 21'h012345, 21'h100001, 21'h100012,
                                  21'h0B0000, 21'h10F001, 21'h100000, 21'h0FFFFF};

    initial begin
        logic [20:0] value;
        rst       = 1'b0;
        bcd_input = 21'h1_98765;
        repeat (3) @(posedge clk);
        #1;
        checkBlank("reset");

        // Release reset away from a clock edge, then walk the directed values.
        @(negedge clk);
        rst = 1'b1;
        foreach (directed[i]) begin
            applyStimulus($sformatf("dir%0d", i), directed[i]);
            if (directed[i] == 21'h012345) begin
                checkOutput("lit12345.out4", out4, 8'hF9);
                checkOutput("lit12345.out3", out3, 8'hA4);
                checkOutput("lit12345.out2", out2, 8'hB0);
                checkOutput("lit12345.out1", out1, 8'h99);
                checkOutput("lit12345.out0", out0, 8'h92);
                checkOutput("lit12345.dout", dout, 8'hFF);
            end
        end

        // Mid-stream reset must darken the display before the next edge.
        applyStimulus("preReset", 21'h112345);
        checkOutput("preReset.minus", dout, 8'hBF);
        #2;
        rst = 1'b0;
        #1;
        checkBlank("midReset");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("postReset", 21'h112345);

        // Randomized values, often with leading zeros so blanking is exercised.
        for (int n = 0; n < 300; n++) begin
            value = 21'($urandom);
            case ($urandom_range(0, 3))
                0: value[19:8]  = 12'h000;
                1: value[19:12] = 8'h00;
                2: value[19:4]  = 16'h0000;
                default: ;
            endcase
            applyStimulus($sformatf("rnd%0d", n), value);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
